// File: rtl/core_ctrl_pkg.sv
// Shared types and instruction-word layout for the attention-core sequencer.
package core_ctrl_pkg;

  localparam int unsigned INST_W = 20;

  localparam int unsigned INST_PMEM_WR     = 0;
  localparam int unsigned INST_PMEM_RD     = 1;
  localparam int unsigned INST_KMEM_WR     = 2;
  localparam int unsigned INST_KMEM_RD     = 3;
  localparam int unsigned INST_QMEM_WR     = 4;
  localparam int unsigned INST_QMEM_RD     = 5;
  localparam int unsigned INST_LOAD        = 6;
  localparam int unsigned INST_EXECUTE     = 7;
  localparam int unsigned INST_OFIFO_RD    = 16;
  localparam int unsigned INST_DIV         = 17;
  localparam int unsigned INST_ACC         = 18;
  localparam int unsigned INST_SFP_PMEM_WR = 19;

  localparam int unsigned PMEM_ADD_LSB  = 8;
  localparam int unsigned PMEM_ADD_W    = 4;
  localparam int unsigned QKMEM_ADD_LSB = 12;
  localparam int unsigned QKMEM_ADD_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_Q, S_LOAD_K, S_KLOAD, S_EXEC, S_DRAIN, S_READBACK, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    PH_WAIT, PH_RD, PH_ACC, PH_DIV, PH_WR
  } drain_phase_e;

endpackage

// File: rtl/core_ctrl_if.sv
// Handshake and instruction bundle between the sequencer and its surroundings.
interface core_ctrl_if;
  import core_ctrl_pkg::*;

  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              ofifo_valid;
  logic [INST_W-1:0] inst;
  logic              busy;
  logic              done;
  logic              out_valid;

  modport master (output start, in_valid, ofifo_valid,
                  input  in_ready, inst, busy, done, out_valid);
  modport slave  (input  start, in_valid, ofifo_valid,
                  output in_ready, inst, busy, done, out_valid);
endinterface

// File: rtl/core_ctrl_drain.sv
// Per-row drain sequencer: WAIT for ofifo data, then RD, ACC, DIV, WR; steps the row counter.
module core_ctrl_drain
  import core_ctrl_pkg::*;
#(
  parameter int unsigned num_q  = 8,
  parameter int unsigned addr_w = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              ofifo_valid,
  output logic              last,
  output logic              rd_c,
  output logic              acc_c,
  output logic              div_c,
  output logic              wr_c,
  output logic [addr_w-1:0] row
);

  localparam logic [addr_w-1:0] LAST_ROW = addr_w'(num_q - 1);

  drain_phase_e      phase_q, phase_d;
  logic [addr_w-1:0] row_q, row_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q <= PH_WAIT;
      row_q   <= '0;
    end else begin
      phase_q <= phase_d;
      row_q   <= row_d;
    end
  end

  // Sequencer parks in WAIT at row 0 whenever it is not enabled.
  always_comb begin
    phase_d = phase_q;
    row_d   = row_q;
    if (!go) begin
      phase_d = PH_WAIT;
      row_d   = '0;
    end else begin
      case (phase_q)
        PH_WAIT: if (ofifo_valid) phase_d = PH_RD;
        PH_RD:   phase_d = PH_ACC;
        PH_ACC:  phase_d = PH_DIV;
        PH_DIV:  phase_d = PH_WR;
        PH_WR: begin
          phase_d = PH_WAIT;
          row_d   = (row_q == LAST_ROW) ? '0 : row_q + addr_w'(1);
        end
        default: phase_d = PH_WAIT;
      endcase
    end
  end

  assign rd_c  = go && (phase_q == PH_RD);
  assign acc_c = go && (phase_q == PH_ACC);
  assign div_c = go && (phase_q == PH_DIV);
  assign wr_c  = go && (phase_q == PH_WR);
  assign last  = wr_c && (row_q == LAST_ROW);
  assign row   = row_q;

endmodule

// File: rtl/core_ctrl.sv
// Attention-core instruction sequencer: load Q/K, stream K, execute, drain rows per start.
// Optional psum readback phase enabled by defining CORE_CTRL_READBACK_EN.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int unsigned col    = 8,
  parameter int unsigned num_q  = 8,
  parameter int unsigned addr_w = 4
) (
  input  logic        clk,
  input  logic        reset,
  core_ctrl_if.slave  bus
);

  // One extra bit so KLOAD/EXEC can count to col / num_q inclusive.
  localparam int unsigned    CNT_W  = addr_w + 1;
  localparam logic [CNT_W-1:0] NQ_C   = CNT_W'(num_q);
  localparam logic [CNT_W-1:0] NQ_M1  = CNT_W'(num_q - 1);
  localparam logic [CNT_W-1:0] COL_C  = CNT_W'(col);
  localparam logic [CNT_W-1:0] COL_M1 = CNT_W'(col - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, done_q, in_ready_q;
  logic [INST_W-1:0] inst_c;

  logic              drain_go, drain_last;
  logic              drain_rd_c, drain_acc_c, drain_div_c, drain_wr_c;
  logic [addr_w-1:0] drain_row;

  assign drain_go = (state_q == S_DRAIN);

  core_ctrl_drain #(.num_q(num_q), .addr_w(addr_w)) u_drain (
    .clk         (clk),
    .reset       (reset),
    .go          (drain_go),
    .ofifo_valid (bus.ofifo_valid),
    .last        (drain_last),
    .rd_c        (drain_rd_c),
    .acc_c       (drain_acc_c),
    .div_c       (drain_div_c),
    .wr_c        (drain_wr_c),
    .row         (drain_row)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
      in_ready_q <= (state_d == S_LOAD_Q) || (state_d == S_LOAD_K);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inst_c  = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD_Q;
          cnt_d   = '0;
        end
      end
      S_LOAD_Q: begin
        inst_c[INST_QMEM_WR] = bus.in_valid;
        inst_c[QKMEM_ADD_LSB +: QKMEM_ADD_W] = QKMEM_ADD_W'(cnt_q);
        if (bus.in_valid) begin
          if (cnt_q == NQ_M1) begin
            state_d = S_LOAD_K;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_LOAD_K: begin
        inst_c[INST_KMEM_WR] = bus.in_valid;
        inst_c[QKMEM_ADD_LSB +: QKMEM_ADD_W] = QKMEM_ADD_W'(cnt_q);
        if (bus.in_valid) begin
          if (cnt_q == COL_M1) begin
            state_d = S_KLOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      // load trails kmem_rd by one cycle to cover the SRAM read latency.
      S_KLOAD: begin
        if (cnt_q < COL_C) begin
          inst_c[INST_KMEM_RD] = 1'b1;
          inst_c[QKMEM_ADD_LSB +: QKMEM_ADD_W] = QKMEM_ADD_W'(cnt_q);
        end
        inst_c[INST_LOAD] = (cnt_q != '0);
        if (cnt_q == COL_C) begin
          state_d = S_EXEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EXEC: begin
        if (cnt_q < NQ_C) begin
          inst_c[INST_QMEM_RD] = 1'b1;
          inst_c[QKMEM_ADD_LSB +: QKMEM_ADD_W] = QKMEM_ADD_W'(cnt_q);
        end
        inst_c[INST_EXECUTE] = (cnt_q != '0);
        if (cnt_q == NQ_C) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        inst_c[INST_OFIFO_RD]    = drain_rd_c;
        inst_c[INST_ACC]         = drain_acc_c;
        inst_c[INST_DIV]         = drain_div_c;
        inst_c[INST_SFP_PMEM_WR] = drain_wr_c;
        inst_c[INST_PMEM_WR]     = drain_wr_c;
        if (drain_wr_c) inst_c[PMEM_ADD_LSB +: PMEM_ADD_W] = PMEM_ADD_W'(drain_row);
        if (drain_last) begin
`ifdef CORE_CTRL_READBACK_EN
          state_d = S_READBACK;
`else
          state_d = S_DONE;
`endif
          cnt_d = '0;
        end
      end
`ifdef CORE_CTRL_READBACK_EN
      S_READBACK: begin
        inst_c[INST_PMEM_RD] = 1'b1;
        inst_c[PMEM_ADD_LSB +: PMEM_ADD_W] = PMEM_ADD_W'(cnt_q);
        if (cnt_q == NQ_M1) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef CORE_CTRL_READBACK_EN
  logic out_valid_q;

  // Readback data appears on the core output one cycle after each pmem_rd.
  always_ff @(posedge clk) begin
    if (!reset) out_valid_q <= 1'b0;
    else        out_valid_q <= (state_q == S_READBACK);
  end

  assign bus.out_valid = out_valid_q;
`else
  assign bus.out_valid = 1'b0;
`endif

  assign bus.inst     = inst_c;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.in_ready = in_ready_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Scoreboard bench for core_ctrl: directed tiles, load/drain stalls and mid-tile reset.
module tb_core_ctrl;

  localparam int NQ  = 8;
  localparam int COL = 8;
  localparam int BIG = 1000000;
  localparam logic [19:0] ADDR_MASK = 20'h0FF00;

  localparam int K_INST = 0;
  localparam int K_OV   = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int          kind;
    logic [19:0] inst;
    int          t;
  } exp_t;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   tcnt   = 0;
  exp_t sb[$];

  core_ctrl_if bus();

  core_ctrl #(.col(COL), .num_q(NQ), .addr_w(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int kind, input logic [19:0] w, input int t, input int tmax);
    exp_t e;
    if (t <= tmax) begin
      e.kind = kind;
      e.inst = w;
      e.t    = t;
      sb.push_back(e);
    end
  endtask

  // Expected event stream for one tile; g = cycles per accepted load word,
  // rows >= srow are delayed by d cycles, events after tmax are not expected.
  task automatic push_tile(input int g, input int srow, input int d, input int tmax);
    logic [19:0] w;
    int ks, es, ds, tt, off;
    for (int a = 0; a < NQ; a++) begin
      w = '0; w[4] = 1'b1; w[15:12] = 4'(a);
      push(K_INST, w, 1 + g * a, tmax);
    end
    for (int a = 0; a < COL; a++) begin
      w = '0; w[2] = 1'b1; w[15:12] = 4'(a);
      push(K_INST, w, 1 + g * (NQ + a), tmax);
    end
    ks = 2 + g * (NQ + COL - 1);
    for (int j = 0; j <= COL; j++) begin
      w = '0;
      if (j < COL) begin w[3] = 1'b1; w[15:12] = 4'(j); end
      if (j >= 1) w[6] = 1'b1;
      push(K_INST, w, ks + j, tmax);
    end
    es = ks + COL + 1;
    for (int i = 0; i <= NQ; i++) begin
      w = '0;
      if (i < NQ) begin w[5] = 1'b1; w[15:12] = 4'(i); end
      if (i >= 1) w[7] = 1'b1;
      push(K_INST, w, es + i, tmax);
    end
    ds = es + NQ + 1;
    for (int r = 0; r < NQ; r++) begin
      off = (r >= srow) ? d : 0;
      w = '0; w[16] = 1'b1; push(K_INST, w, ds + 5 * r + 1 + off, tmax);
      w = '0; w[18] = 1'b1; push(K_INST, w, ds + 5 * r + 2 + off, tmax);
      w = '0; w[17] = 1'b1; push(K_INST, w, ds + 5 * r + 3 + off, tmax);
      w = '0; w[19] = 1'b1; w[0] = 1'b1; w[11:8] = 4'(r);
      push(K_INST, w, ds + 5 * r + 4 + off, tmax);
    end
    tt = ds + 5 * NQ + d;
`ifdef CORE_CTRL_READBACK_EN
    for (int r = 0; r < NQ; r++) begin
      w = '0; w[1] = 1'b1; w[11:8] = 4'(r);
      push(K_INST, w, tt + r, tmax);
      if (r >= 1) push(K_OV, '0, tt + r, tmax);
    end
    tt = tt + NQ;
    push(K_OV, '0, tt, tmax);
`endif
    push(K_DONE, '0, tt, tmax);
  endtask

  task automatic check_ev(input int kind, input logic [19:0] iw);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected kind=%0d inst=%05h t=%0d (no event expected)", kind, iw, tcnt);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || (kind == K_INST && e.inst != iw) || e.t != tcnt) begin
        errors++;
        $display("FAIL sb_event got kind=%0d inst=%05h t=%0d, expected kind=%0d inst=%05h t=%0d",
                 kind, iw, tcnt, e.kind, e.inst, e.t);
      end
    end
  endtask

  // Monitor: every cycle with a non-address inst bit, out_valid or done is an event.
  always @(negedge clk) begin
    tcnt = tcnt + 1;
    if ((bus.inst & ~ADDR_MASK) != 20'h0) check_ev(K_INST, bus.inst);
    if (bus.out_valid) check_ev(K_OV, '0);
    if (bus.done) check_ev(K_DONE, '0);
    if (bus.start && !bus.busy && reset) tcnt = 0;
  end

  task automatic chk(input string name, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%05h expected=%05h", name, got, exp);
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || bus.busy) begin
      errors++;
      $display("FAIL tile_timeout pending=%0d busy=%0b expected pending=0 busy=0", sb.size(), bus.busy);
      sb.delete();
    end
  endtask

  initial begin
    int wr_seen, n;
    reset           = 1'b0;
    bus.start       = 1'b1;
    bus.in_valid    = 1'b0;
    bus.ofifo_valid = 1'b1;

    // Reset held with start asserted: everything stays quiet.
    repeat (3) begin
      @(negedge clk);
      chk("rst_inst", bus.inst, 20'h0);
      chk("rst_busy", 20'(bus.busy), 20'h0);
      chk("rst_done", 20'(bus.done), 20'h0);
      chk("rst_in_ready", 20'(bus.in_ready), 20'h0);
      chk("rst_out_valid", 20'(bus.out_valid), 20'h0);
    end
    @(posedge clk); #1 reset = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    chk("idle_busy", 20'(bus.busy), 20'h0);

    // Full tile, no stalls.
    bus.in_valid = 1'b1;
    push_tile(1, NQ, 0, BIG);
    do_start();
    chk("start_busy", 20'(bus.busy), 20'h1);
    chk("start_in_ready", 20'(bus.in_ready), 20'h1);
    wait_idle(400);

    // Load stall: in_valid alternates 1/0 starting in the first LOAD_Q cycle.
    bus.in_valid = 1'b0;
    push_tile(2, NQ, 0, BIG);
    do_start();
    bus.in_valid = 1'b1;
    repeat (40) begin
      @(posedge clk); #1 bus.in_valid = ~bus.in_valid;
    end
    bus.in_valid = 1'b0;
    wait_idle(400);

    // Drain stall at row 3: ofifo_valid low for 10 cycles from the row-2 write.
    bus.in_valid = 1'b1;
    push_tile(1, 3, 9, BIG);
    do_start();
    wr_seen = 0;
    n = 0;
    while (wr_seen < 3 && n < 200) begin
      @(negedge clk);
      if (bus.inst[19]) wr_seen++;
      n++;
    end
    checks++;
    if (wr_seen < 3) begin
      errors++;
      $display("FAIL drain_wr_timeout got=%0d writes expected=3", wr_seen);
    end
    bus.ofifo_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("drain_stall_rd", 20'(bus.inst[16]), 20'h0);
    end
    bus.ofifo_valid = 1'b1;
    wait_idle(400);

    // Reset sampled at the edge ending EXEC cycle 4 (tile cycle 30).
    push_tile(1, NQ, 0, 30);
    do_start();
    repeat (29) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_inst", bus.inst, 20'h0);
    chk("midrst_busy", 20'(bus.busy), 20'h0);
    chk("midrst_pending", 20'(sb.size()), 20'h0);
    sb.delete();
    @(posedge clk); #1 reset = 1'b1;

    // Rerun after reset starts again from LOAD_Q address 0.
    push_tile(1, NQ, 0, BIG);
    do_start();
    wait_idle(400);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_busy", 20'(bus.busy), 20'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
